// File: rtl/iob_axi_master_bridge_if.sv
// Bus bundles for the native-to-AXI bridge: the native single-word port and the
// AXI4 master port. Signal names inside each interface follow the bus names.
interface iob_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic                  valid;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;
    logic                  error;

    modport master (output valid, addr, wdata, wstrb, input rdata, ready, error);
    modport slave  (input valid, addr, wdata, wstrb, output rdata, ready, error);
endinterface

interface axi4_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32,
    parameter int ID_W   = 1
);
    logic [ID_W-1:0]     m_axi_awid;
    logic [ADDR_W-1:0]   m_axi_awaddr;
    logic [7:0]          m_axi_awlen;
    logic [2:0]          m_axi_awsize;
    logic [1:0]          m_axi_awburst;
    logic                m_axi_awlock;
    logic [3:0]          m_axi_awcache;
    logic [2:0]          m_axi_awprot;
    logic [3:0]          m_axi_awqos;
    logic                m_axi_awvalid;
    logic                m_axi_awready;
    logic [DATA_W-1:0]   m_axi_wdata;
    logic [DATA_W/8-1:0] m_axi_wstrb;
    logic                m_axi_wlast;
    logic                m_axi_wvalid;
    logic                m_axi_wready;
    logic [ID_W-1:0]     m_axi_bid;
    logic [1:0]          m_axi_bresp;
    logic                m_axi_bvalid;
    logic                m_axi_bready;
    logic [ID_W-1:0]     m_axi_arid;
    logic [ADDR_W-1:0]   m_axi_araddr;
    logic [7:0]          m_axi_arlen;
    logic [2:0]          m_axi_arsize;
    logic [1:0]          m_axi_arburst;
    logic                m_axi_arlock;
    logic [3:0]          m_axi_arcache;
    logic [2:0]          m_axi_arprot;
    logic [3:0]          m_axi_arqos;
    logic                m_axi_arvalid;
    logic                m_axi_arready;
    logic [ID_W-1:0]     m_axi_rid;
    logic [DATA_W-1:0]   m_axi_rdata;
    logic [1:0]          m_axi_rresp;
    logic                m_axi_rlast;
    logic                m_axi_rvalid;
    logic                m_axi_rready;

    modport master (
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
               m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
               m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
               m_axi_rready,
        input  m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid,
               m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
               m_axi_rvalid
    );
    modport slave (
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
               m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
               m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
               m_axi_rready,
        output m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid,
               m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
               m_axi_rvalid
    );
endinterface

// File: rtl/iob_axi_master_bridge.sv
// Native single-word request -> one AXI4 single-beat read or write, one at a time.
// Every output is driven from a register or a constant.
module iob_axi_master_bridge #(
    parameter int              ADDR_W = 24,
    parameter int              DATA_W = 32,
    parameter int              ID_W   = 1,
    parameter logic [ID_W-1:0] AXI_ID = '0
) (
    input  logic   clk,
    input  logic   rst,
    iob_if.slave   iob,
    axi4_if.master axi
);
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WRESP, S_RADDR, S_RDATA, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  ready_q, ready_d;
    logic                  error_q, error_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        ready_d   = ready_q;
        error_d   = error_q;
        case (state_q)
            S_IDLE: begin
                if (iob.valid) begin
                    addr_d  = {iob.addr[ADDR_W-1:2], 2'b00};
                    wdata_d = iob.wdata;
                    wstrb_d = iob.wstrb;
                    if (|iob.wstrb) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WRITE;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_RADDR;
                    end
                end
            end
            S_WRITE: begin
                // AW and W retire independently; B is accepted once both are gone.
                if (axi.m_axi_awready) awvalid_d = 1'b0;
                if (axi.m_axi_wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = S_WRESP;
                end
            end
            S_WRESP: begin
                if (axi.m_axi_bvalid) begin
                    bready_d = 1'b0;
                    error_d  = (axi.m_axi_bresp != 2'b00);
                    ready_d  = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_RADDR: begin
                if (axi.m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (axi.m_axi_rvalid) begin
                    rdata_d  = axi.m_axi_rdata;
                    error_d  = (axi.m_axi_rresp != 2'b00);
                    rready_d = 1'b0;
                    ready_d  = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                ready_d = 1'b0;
                error_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign iob.rdata = rdata_q;
    assign iob.ready = ready_q;
    assign iob.error = error_q;

    assign axi.m_axi_awid    = AXI_ID;
    assign axi.m_axi_awaddr  = addr_q;
    assign axi.m_axi_awlen   = 8'd0;
    assign axi.m_axi_awsize  = 3'd2;
    assign axi.m_axi_awburst = 2'b01;
    assign axi.m_axi_awlock  = 1'b0;
    assign axi.m_axi_awcache = 4'b0011;
    assign axi.m_axi_awprot  = 3'd0;
    assign axi.m_axi_awqos   = 4'd0;
    assign axi.m_axi_awvalid = awvalid_q;
    assign axi.m_axi_wdata   = wdata_q;
    assign axi.m_axi_wstrb   = wstrb_q;
    assign axi.m_axi_wlast   = 1'b1;
    assign axi.m_axi_wvalid  = wvalid_q;
    assign axi.m_axi_bready  = bready_q;
    assign axi.m_axi_arid    = AXI_ID;
    assign axi.m_axi_araddr  = addr_q;
    assign axi.m_axi_arlen   = 8'd0;
    assign axi.m_axi_arsize  = 3'd2;
    assign axi.m_axi_arburst = 2'b01;
    assign axi.m_axi_arlock  = 1'b0;
    assign axi.m_axi_arcache = 4'b0011;
    assign axi.m_axi_arprot  = 3'd0;
    assign axi.m_axi_arqos   = 4'd0;
    assign axi.m_axi_arvalid = arvalid_q;
    assign axi.m_axi_rready  = rready_q;

    // IDs and rlast carry no information for single-beat, single-outstanding traffic.
    logic unused_ok;
    assign unused_ok = ^{axi.m_axi_bid, axi.m_axi_rid, axi.m_axi_rlast, iob.addr[1:0]};
endmodule

// File: tb/tb_iob_axi_master_bridge.sv
// Bench: native-side driver, behavioural AXI slave with per-channel delays and a
// response scoreboard checked on every ready pulse.
module tb_iob_axi_master_bridge;
    logic clk, rst;
    int   total, bad, cyc;

    iob_if  #(.ADDR_W(24), .DATA_W(32))            u_iob ();
    axi4_if #(.ADDR_W(24), .DATA_W(32), .ID_W(1))  u_axi ();

    iob_axi_master_bridge #(.ADDR_W(24), .DATA_W(32), .ID_W(1), .AXI_ID(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .iob (u_iob.slave),
        .axi (u_axi.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- AXI slave model ----------------
    logic [31:0] mem [int];
    int          aw_dly, w_dly, b_dly, r_dly;
    logic [1:0]  bresp_cfg, rresp_cfg;
    int          aw_w, w_w, b_w, r_w;
    bit          aw_got, w_got, ar_got;
    logic [23:0] aw_addr, ar_addr;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last;
    int          aw_cnt, w_cnt, ar_cnt, early_b;

    function automatic logic [31:0] mem_rd(input logic [23:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : 32'h0;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            aw_got = 0; w_got = 0; ar_got = 0;
        end else begin
            if (u_axi.m_axi_bready && !(aw_got && w_got)) early_b++;
            if (u_axi.m_axi_awvalid && u_axi.m_axi_awready) begin
                aw_got = 1; aw_addr = u_axi.m_axi_awaddr; aw_cnt++;
            end
            if (u_axi.m_axi_wvalid && u_axi.m_axi_wready) begin
                w_got = 1; w_data = u_axi.m_axi_wdata; w_strb = u_axi.m_axi_wstrb;
                w_last = u_axi.m_axi_wlast; w_cnt++;
            end
            if (u_axi.m_axi_bvalid && u_axi.m_axi_bready) begin
                logic [31:0] old;
                old = mem_rd(aw_addr);
                for (int i = 0; i < 4; i++)
                    if (w_strb[i]) old[i*8 +: 8] = w_data[i*8 +: 8];
                mem[int'(aw_addr)] = old;
                aw_got = 0; w_got = 0;
            end
            if (u_axi.m_axi_arvalid && u_axi.m_axi_arready) begin
                ar_got = 1; ar_addr = u_axi.m_axi_araddr; ar_cnt++;
            end
            if (u_axi.m_axi_rvalid && u_axi.m_axi_rready) ar_got = 0;
        end
    end

    always @(negedge clk) begin
        u_axi.m_axi_bid   = 1'b0;
        u_axi.m_axi_rid   = 1'b0;
        u_axi.m_axi_rlast = 1'b1;
        if (!rst) begin
            u_axi.m_axi_awready = 0; u_axi.m_axi_wready = 0; u_axi.m_axi_arready = 0;
            u_axi.m_axi_bvalid = 0; u_axi.m_axi_rvalid = 0; u_axi.m_axi_bresp = 0;
            u_axi.m_axi_rresp = 0; u_axi.m_axi_rdata = 0;
            aw_w = 0; w_w = 0; b_w = 0; r_w = 0;
        end else begin
            u_axi.m_axi_awready = u_axi.m_axi_awvalid && (aw_w >= aw_dly);
            if (u_axi.m_axi_awvalid && !u_axi.m_axi_awready) aw_w++; else aw_w = 0;
            u_axi.m_axi_wready = u_axi.m_axi_wvalid && (w_w >= w_dly);
            if (u_axi.m_axi_wvalid && !u_axi.m_axi_wready) w_w++; else w_w = 0;
            u_axi.m_axi_arready = u_axi.m_axi_arvalid;
            if (u_axi.m_axi_bready && aw_got && w_got) begin
                if (b_w >= b_dly) u_axi.m_axi_bvalid = 1; else b_w++;
                u_axi.m_axi_bresp = bresp_cfg;
            end else begin
                u_axi.m_axi_bvalid = 0; b_w = 0;
            end
            if (u_axi.m_axi_rready && ar_got) begin
                if (r_w >= r_dly) u_axi.m_axi_rvalid = 1; else r_w++;
                u_axi.m_axi_rdata = mem_rd(ar_addr);
                u_axi.m_axi_rresp = rresp_cfg;
            end else begin
                u_axi.m_axi_rvalid = 0; r_w = 0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { bit is_rd; logic [31:0] rdata; logic err; } exp_t;
    exp_t sb[$];
    int   rdy_cnt;

    always @(negedge clk) begin
        if (rst && u_iob.ready) begin
            exp_t e;
            rdy_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_ready", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("error", u_iob.error, e.err);
                if (e.is_rd) chk("rdata", u_iob.rdata, e.rdata);
            end
        end
    end

    task automatic do_req(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int   t0;
        bit   got;
        exp_t e;
        @(negedge clk);
        u_iob.valid = 1; u_iob.addr = a; u_iob.wdata = d; u_iob.wstrb = s;
        e.is_rd = (s == 4'h0); e.rdata = exp_rd; e.err = exp_err;
        sb.push_back(e);
        t0 = cyc;
        @(negedge clk);
        u_iob.valid = 0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (u_iob.ready) got = 1;
            else @(negedge clk);
        end
        chk("ready_timeout", got, 1);
        if (got) chk("latency", cyc - t0, exp_lat);
        @(negedge clk);
    endtask

    initial begin
        int a0, w0, r0, n0;
        bit hit;
        total = 0; bad = 0; cyc = 0;
        aw_dly = 0; w_dly = 0; b_dly = 0; r_dly = 0; bresp_cfg = 0; rresp_cfg = 0;
        u_iob.valid = 0; u_iob.addr = 0; u_iob.wdata = 0; u_iob.wstrb = 0;
        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {u_axi.m_axi_awvalid, u_axi.m_axi_wvalid, u_axi.m_axi_bready,
                         u_axi.m_axi_arvalid, u_axi.m_axi_rready, u_iob.ready, u_iob.error}, 0);
        chk("rst_rdata", u_iob.rdata, 0);
        chk("const_aw", {u_axi.m_axi_awlen, u_axi.m_axi_awsize, u_axi.m_axi_awburst,
                         u_axi.m_axi_awcache, u_axi.m_axi_wlast}, {8'd0, 3'd2, 2'b01, 4'b0011, 1'b1});
        @(negedge clk) rst = 1;

        // basic write then read-back with unaligned address
        do_req(24'h000104, 32'hDEADBEEF, 4'hF, 0, 0, 3);
        chk("awaddr", aw_addr, 24'h000104);
        chk("wdata", w_data, 32'hDEADBEEF);
        chk("wstrb", w_strb, 4'hF);
        chk("wlast", w_last, 1);
        do_req(24'h000106, 0, 4'h0, 32'hDEADBEEF, 0, 3);
        chk("araddr", ar_addr, 24'h000104);

        // W delayed behind AW, then AW delayed behind W
        a0 = aw_cnt; w0 = w_cnt; n0 = rdy_cnt;
        w_dly = 4;
        do_req(24'h000200, 32'h11223344, 4'h3, 0, 0, 7);
        w_dly = 0; aw_dly = 4;
        do_req(24'h000204, 32'hCAFEF00D, 4'hC, 0, 0, 7);
        aw_dly = 0;
        chk("early_bready", early_b, 0);
        chk("aw_count", aw_cnt - a0, 2);
        chk("w_count", w_cnt - w0, 2);
        chk("ready_count", rdy_cnt - n0, 2);
        do_req(24'h000200, 0, 4'h0, 32'h00003344, 0, 3);
        do_req(24'h000204, 0, 4'h0, 32'hCAFE0000, 0, 3);

        // error responses
        rresp_cfg = 2'b10;
        do_req(24'h000104, 0, 4'h0, 32'hDEADBEEF, 1, 3);
        rresp_cfg = 2'b00;
        do_req(24'h000200, 0, 4'h0, 32'h00003344, 0, 3);
        bresp_cfg = 2'b11;
        do_req(24'h000300, 32'h01020304, 4'h1, 0, 1, 3);
        bresp_cfg = 2'b00;

        // second valid while waiting on read data is ignored
        a0 = aw_cnt; r0 = ar_cnt; r_dly = 6;
        fork
            do_req(24'h000104, 0, 4'h0, 32'hDEADBEEF, 0, 9);
            begin
                hit = 0;
                for (int i = 0; i < 20 && !hit; i++) begin
                    @(negedge clk);
                    if (u_axi.m_axi_rready) hit = 1;
                end
                chk("rdata_wait_seen", hit, 1);
                @(negedge clk);
                u_iob.valid = 1; u_iob.addr = 24'h000400; u_iob.wstrb = 4'hF;
                @(negedge clk);
                u_iob.valid = 0;
            end
        join
        r_dly = 0;
        repeat (3) @(negedge clk);
        chk("ar_count", ar_cnt - r0, 1);
        chk("aw_ignored", aw_cnt - a0, 0);

        // reset while waiting on the write response
        b_dly = 20; n0 = rdy_cnt;
        @(negedge clk);
        u_iob.valid = 1; u_iob.addr = 24'h00010C; u_iob.wdata = 32'h12345678; u_iob.wstrb = 4'hF;
        @(negedge clk);
        u_iob.valid = 0;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (u_axi.m_axi_bready) hit = 1; else @(negedge clk);
        end
        chk("wresp_reached", hit, 1);
        rst = 0;
        @(posedge clk);
        #1;
        chk("abort_outs", {u_axi.m_axi_awvalid, u_axi.m_axi_wvalid, u_axi.m_axi_bready,
                           u_axi.m_axi_arvalid, u_axi.m_axi_rready, u_iob.ready, u_iob.error}, 0);
        @(negedge clk);
        rst = 1; b_dly = 0;
        repeat (4) @(negedge clk);
        chk("abort_noready", rdy_cnt - n0, 0);
        do_req(24'h000108, 32'h55AA00FF, 4'hF, 0, 0, 3);
        do_req(24'h000108, 0, 4'h0, 32'h55AA00FF, 0, 3);
        do_req(24'h00010C, 0, 4'h0, 32'h00000000, 0, 3);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
